uart_tx_arb: RTL and testbench
==============================

UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters sharing one uart_tx; legal range 2..16.
REQ-002 Parameter W_OUT, default 24: payload/beat width, equal to the uart_tx word-vector width; must be >= 8.
REQ-003 Parameter HEADER_EN, default 1: 1 = each payload preceded by a header beat; 0 = payload only.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rstn  input  1  reset, synchronous, active-low.
REQ-006 s_valid  input  N_REQ  per-requester payload valid.
REQ-007 s_data  input  N_REQ x W_OUT  per-requester payload, packed array.
REQ-008 s_ready  output  N_REQ  per-requester accept strobe, at most one bit high.
REQ-009 m_valid  output  1  beat valid toward uart_tx s_valid.
REQ-010 m_data  output  W_OUT  beat toward uart_tx s_data.
REQ-011 m_ready  input  1  from uart_tx s_ready.
REQ-012 grant_id  output  clog2(N_REQ)  index of requester currently owning the transmitter.
REQ-013 busy  output  1  high in any state other than IDLE.

Function
REQ-014 States: IDLE, HDR, DATA; HDR reachable only when HEADER_EN=1.
REQ-015 Upstream transfer on s_valid[i] && s_ready[i]; downstream transfer on m_valid && m_ready.
REQ-016 In IDLE, if any s_valid bit is set, winner = first set bit searching from ptr+1 upward, wrapping modulo N_REQ.
REQ-017 In IDLE, s_ready[winner] asserted combinationally in the same cycle; all s_ready bits low in HDR and DATA.
REQ-018 On upstream transfer: payload register <= s_data[winner], grant_id <= winner, ptr <= winner, state <= HDR (HEADER_EN=1) or DATA (HEADER_EN=0).
REQ-019 m_valid registered: rises the cycle after the upstream transfer (latency 1); low in IDLE.
REQ-020 HDR: m_data = header beat, bits [7:4] = HDR_TAG (4'hA), bits [3:0] = grant_id zero-extended, bits [W_OUT-1:8] = 0.
REQ-021 DATA: m_data = captured payload register.
REQ-022 m_valid and m_data held stable while m_valid && !m_ready.
REQ-023 HDR -> DATA on m_ready; DATA -> IDLE on m_ready, m_valid deasserted the same edge.
REQ-024 m_ready while in IDLE is ignored; no transfer counted.
REQ-025 A granted requester's s_valid/s_data changes after its upstream transfer have no effect on the packet in flight.
REQ-026 Minimum one IDLE cycle between packets; back-to-back requests from a single requester are served one packet per (beats + 1) cycles at m_ready=1.
REQ-027 With all requesters continuously valid, grant order after reset is 0,1,...,N_REQ-1,0,... (no starvation).
REQ-028 No packet interleaving: a granted packet's header and payload beats are consecutive downstream transfers.

Reset
REQ-029 On rstn=0 at a clock edge: state=IDLE, m_valid=0, m_data=0, grant_id=0, busy=0, payload register=0, ptr=N_REQ-1.
REQ-030 s_ready is forced to all-zero while rstn=0.
REQ-031 Reset mid-packet aborts the packet with no further beats; the aborted requester is not re-served unless it re-presents s_valid.

Structure
REQ-032 Shared package uart_pkg holds HDR_TAG constant and the arbiter state enum typedef.
REQ-033 One sub-module, rr_pick: combinational round-robin selector (request vector, ptr -> one-hot grant, index, any); instantiated once.
REQ-034 Output connects directly to uart_tx (m_valid->s_valid, m_data->s_data, m_ready<-s_ready) with no glue logic.

Verification
REQ-035 Reset, then s_valid=4'b0100, s_data[2]=24'h123456, m_ready=1 -> s_ready=4'b0100 same cycle; beats 24'h0000A2 then 24'h123456; grant_id=2.
REQ-036 All four s_valid held high, m_ready=1, HEADER_EN=1 -> header low bytes A0,A1,A2,A3,A0 in order; each header followed by the matching payload.
REQ-037 m_ready=0 for 10 cycles during DATA -> m_valid and m_data unchanged for all 10 cycles; transfer occurs on the first m_ready=1 cycle.
REQ-038 HEADER_EN=0, requester 1 continuously valid, m_ready=1 -> a payload beat every 2 cycles with one IDLE cycle between beats; no header beats.
REQ-039 rstn=0 asserted during HDR -> next cycle m_valid=0, busy=0, s_ready=0; after release, requester 0 is served first.
REQ-040 Requester 3 drops s_valid and changes s_data the cycle after its upstream transfer -> transmitted payload equals the originally captured value.

Source files
------------

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the uart_tx arbiter: the header tag nibble and the
// arbiter state encoding.
// No ports (package).
// ---------------------------------------------------------------------------
package uart_pkg;

  localparam logic [3:0] HDR_TAG = 4'hA;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin selector. The winner is the first set request
// bit found searching upward from i_ptr+1, wrapping modulo N_REQ.
// Ports:
//   i_req  [N_REQ-1:0]  request vector
//   i_ptr  [IDX_W-1:0]  index of the last winner
//   o_gnt  [N_REQ-1:0]  one-hot grant (all zero when no request)
//   o_idx  [IDX_W-1:0]  index of the winner
//   o_any               at least one request present
// ---------------------------------------------------------------------------
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N_REQ-1:0] o_gnt,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any
);

  // Each requester's distance from ptr+1 in wrap order; smallest wins.
  // Iterating over constant j keeps all bit selects static.
  always_comb begin
    int w_best_d;
    int w_d;
    w_best_d = N_REQ;
    w_d      = 0;
    o_idx    = '0;
    for (int j = 0; j < N_REQ; j++) begin
      w_d = (j + N_REQ - 1 - int'(i_ptr)) % N_REQ;
      if (i_req[j] && (w_d < w_best_d)) begin
        w_best_d = w_d;
        o_idx    = IDX_W'(j);
      end
    end
    o_any = |i_req;
    o_gnt = '0;
    if (o_any) o_gnt[o_idx] = 1'b1;
  end

endmodule

// File: rtl/uart_tx_arb.sv
// ---------------------------------------------------------------------------
// uart_tx_arb
// Round-robin arbiter letting N_REQ requesters share one uart_tx. Each
// accepted payload is sent as an optional header beat followed by the
// payload beat, with no interleaving between packets.
// Ports:
//   clk                         rising-edge clock
//   rstn                        synchronous active-low reset
//   s_valid  [N_REQ-1:0]        per-requester payload valid
//   s_data   [N_REQ-1:0][W_OUT] per-requester payload
//   s_ready  [N_REQ-1:0]        per-requester accept strobe (one-hot or 0)
//   m_valid                     beat valid toward uart_tx
//   m_data   [W_OUT-1:0]        beat toward uart_tx
//   m_ready                     uart_tx ready
//   grant_id [clog2(N_REQ)-1:0] owner of the transmitter
//   busy                        arbiter not idle
// ---------------------------------------------------------------------------
module uart_tx_arb
  import uart_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int W_OUT     = 24,
  parameter int HEADER_EN = 1
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [N_REQ-1:0]              s_valid,
  input  logic [N_REQ-1:0][W_OUT-1:0]   s_data,
  output logic [N_REQ-1:0]              s_ready,
  output logic                          m_valid,
  output logic [W_OUT-1:0]              m_data,
  input  logic                          m_ready,
  output logic [$clog2(N_REQ)-1:0]      grant_id,
  output logic                          busy
);

  localparam int IDX_W = $clog2(N_REQ);

  arb_state_t       r_state;
  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W-1:0] r_gid;
  logic [W_OUT-1:0] r_payload;
  logic [W_OUT-1:0] r_mdata;
  logic             r_mvalid;

  logic [N_REQ-1:0] w_gnt;
  logic [IDX_W-1:0] w_idx;
  logic             w_any;
  logic             w_up;
  logic [W_OUT-1:0] w_hdr;

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .i_req (s_valid),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  // The winner is accepted in the same cycle; rstn gates s_ready so nothing
  // is consumed while reset is held.
  assign w_up    = rstn && (r_state == ST_IDLE) && w_any;
  assign s_ready = w_up ? w_gnt : '0;

  always_comb begin
    w_hdr      = '0;
    w_hdr[7:4] = HDR_TAG;
    w_hdr[3:0] = 4'(w_idx);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state   <= ST_IDLE;
      r_ptr     <= IDX_W'(N_REQ - 1);
      r_gid     <= '0;
      r_payload <= '0;
      r_mdata   <= '0;
      r_mvalid  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_up) begin
            r_payload <= s_data[w_idx];
            r_gid     <= w_idx;
            r_ptr     <= w_idx;
            r_mvalid  <= 1'b1;
            if (HEADER_EN != 0) begin
              r_state <= ST_HDR;
              r_mdata <= w_hdr;
            end else begin
              r_state <= ST_DATA;
              r_mdata <= s_data[w_idx];
            end
          end
        end
        ST_HDR: begin
          if (m_ready) begin
            r_state <= ST_DATA;
            r_mdata <= r_payload;
          end
        end
        ST_DATA: begin
          if (m_ready) begin
            r_state  <= ST_IDLE;
            r_mvalid <= 1'b0;
          end
        end
        default: begin
          r_state  <= ST_IDLE;
          r_mvalid <= 1'b0;
        end
      endcase
    end
  end

  assign m_valid  = r_mvalid;
  assign m_data   = r_mdata;
  assign grant_id = r_gid;
  assign busy     = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_arb.sv
module tb_uart_tx_arb;

  localparam int N = 4;
  localparam int W = 24;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT with header beats
  logic              rstn;
  logic [N-1:0]      sv;
  logic [N-1:0][W-1:0] sd;
  logic [N-1:0]      srdy;
  logic              mv;
  logic [W-1:0]      md;
  logic              mr;
  logic [1:0]        gid;
  logic              busy;

  // DUT without header beats
  logic              rstn2;
  logic [N-1:0]      sv2;
  logic [N-1:0][W-1:0] sd2;
  logic [N-1:0]      srdy2;
  logic              mv2;
  logic [W-1:0]      md2;
  logic              mr2;
  logic [1:0]        gid2;
  logic              busy2;

  uart_tx_arb #(.N_REQ(N), .W_OUT(W), .HEADER_EN(1)) u_dut (
    .clk(clk), .rstn(rstn), .s_valid(sv), .s_data(sd), .s_ready(srdy),
    .m_valid(mv), .m_data(md), .m_ready(mr), .grant_id(gid), .busy(busy)
  );

  uart_tx_arb #(.N_REQ(N), .W_OUT(W), .HEADER_EN(0)) u_dut_nohdr (
    .clk(clk), .rstn(rstn2), .s_valid(sv2), .s_data(sd2), .s_ready(srdy2),
    .m_valid(mv2), .m_data(md2), .m_ready(mr2), .grant_id(gid2), .busy(busy2)
  );

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    sv   = '0;
    sd   = '0;
    mr   = 1'b0;
    cyc();
    rstn = 1'b1;
  endtask

  function automatic logic [23:0] hdr(input int id);
    return {16'h0000, 4'hA, 4'(id)};
  endfunction

  typedef struct {
    logic        rstn;
    logic [3:0]  sv;
    logic [23:0] sd;
    logic        mr;
    logic [3:0]  ex_rdy;
    logic        ex_mv;
    logic [23:0] ex_md;
    logic        ex_busy;
    logic [1:0]  ex_gid;
  } vec_t;

  vec_t vt[16];

  // behavioural model state for the random phase
  logic [23:0] q[$];
  int          m_ptr;
  int          m_gid;
  bit          m_idle;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [23:0] beats[$];
    logic [31:0] act;
    int          win;
    logic [1:0]  jj;

    rstn = 1'b0; sv = '0; sd = '0; mr = 1'b0;
    rstn2 = 1'b0; sv2 = '0; sd2 = '0; mr2 = 1'b0;
    cyc();
    cyc();
    rstn2 = 1'b1;

    // ---------------- table: single packet, stall, rr pointer ----------------
    vt[0]  = '{1'b0, 4'b0100, 24'h123456, 1'b1, 4'b0000, 1'b0, 24'h000000, 1'b0, 2'd0};
    vt[1]  = '{1'b1, 4'b0100, 24'h123456, 1'b1, 4'b0100, 1'b0, 24'h000000, 1'b0, 2'd0};
    vt[2]  = '{1'b1, 4'b0000, 24'h000000, 1'b1, 4'b0000, 1'b1, 24'h0000A2, 1'b1, 2'd2};
    for (int i = 3; i <= 12; i++)
      vt[i] = '{1'b1, 4'b0000, 24'h000000, 1'b0, 4'b0000, 1'b1, 24'h123456, 1'b1, 2'd2};
    vt[13] = '{1'b1, 4'b0000, 24'h000000, 1'b1, 4'b0000, 1'b1, 24'h123456, 1'b1, 2'd2};
    vt[14] = '{1'b1, 4'b0000, 24'h000000, 1'b1, 4'b0000, 1'b0, 24'h000000, 1'b0, 2'd2};
    vt[15] = '{1'b1, 4'b0001, 24'h777777, 1'b0, 4'b0001, 1'b0, 24'h000000, 1'b0, 2'd2};

    for (int i = 0; i < 16; i++) begin
      rstn = vt[i].rstn;
      sv   = vt[i].sv;
      for (int l = 0; l < N; l++) sd[l] = vt[i].sd;
      mr   = vt[i].mr;
      @(negedge clk);
      chk($sformatf("vec%0d s_ready", i), 32'(srdy), 32'(vt[i].ex_rdy));
      chk($sformatf("vec%0d m_valid", i), 32'(mv), 32'(vt[i].ex_mv));
      chk($sformatf("vec%0d busy", i), 32'(busy), 32'(vt[i].ex_busy));
      chk($sformatf("vec%0d grant_id", i), 32'(gid), 32'(vt[i].ex_gid));
      if (vt[i].ex_mv || !vt[i].rstn)
        chk($sformatf("vec%0d m_data", i), 32'(md), 32'(vt[i].ex_md));
      cyc();
    end

    // ---------------- all requesters valid: fair order ----------------
    do_reset();
    sv = 4'hF;
    for (int l = 0; l < N; l++) sd[l] = 24'hC0DE00 | 24'(l);
    mr = 1'b1;
    beats.delete();
    for (int c = 0; c < 40 && beats.size() < 10; c++) begin
      @(negedge clk);
      if (mv && mr) beats.push_back(md);
      cyc();
    end
    chk("rr beat count", 32'(beats.size()), 32'd10);
    for (int b = 0; b < 10; b++) begin
      act = (b < beats.size()) ? 32'(beats[b]) : 32'hDEAD_BEEF;
      if (b % 2 == 0) chk($sformatf("rr beat%0d header", b), act, 32'(hdr((b / 2) % 4)));
      else            chk($sformatf("rr beat%0d payload", b), act, 32'(24'hC0DE00 | 24'((b / 2) % 4)));
    end

    // ---------------- reset during header ----------------
    do_reset();
    sv = 4'hF;
    for (int l = 0; l < N; l++) sd[l] = 24'hC0DE00 | 24'(l);
    mr = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (c == 3) chk("rst seq second grant s_ready", 32'(srdy), 32'b0010);
      cyc();
    end
    @(negedge clk);
    chk("rst seq in hdr m_valid", 32'(mv), 32'd1);
    chk("rst seq in hdr m_data", 32'(md), 32'(hdr(1)));
    cyc();
    rstn = 1'b0;
    @(negedge clk);
    chk("rst seq s_ready forced low", 32'(srdy), 32'd0);
    cyc();
    @(negedge clk);
    chk("rst seq after rst m_valid", 32'(mv), 32'd0);
    chk("rst seq after rst busy", 32'(busy), 32'd0);
    chk("rst seq after rst s_ready", 32'(srdy), 32'd0);
    chk("rst seq after rst grant_id", 32'(gid), 32'd0);
    cyc();
    rstn = 1'b1;
    @(negedge clk);
    chk("rst seq first after release", 32'(srdy), 32'b0001);
    cyc();
    @(negedge clk);
    chk("rst seq release m_data", 32'(md), 32'(hdr(0)));
    chk("rst seq release grant_id", 32'(gid), 32'd0);
    cyc();

    // ---------------- payload isolation after capture ----------------
    do_reset();
    sv = 4'b1000;
    sd[3] = 24'hABCDEF;
    mr = 1'b1;
    @(negedge clk);
    chk("iso s_ready", 32'(srdy), 32'b1000);
    cyc();
    sv = 4'b0000;
    sd[3] = 24'h555555;
    @(negedge clk);
    chk("iso header", 32'(md), 32'(hdr(3)));
    cyc();
    @(negedge clk);
    chk("iso payload valid", 32'(mv), 32'd1);
    chk("iso payload", 32'(md), 32'hABCDEF);
    cyc();
    @(negedge clk);
    chk("iso back to idle", 32'(mv), 32'd0);
    cyc();

    // ---------------- no-header variant, one requester streaming ----------------
    sv2 = 4'b0010;
    mr2 = 1'b1;
    for (int k = 0; k < 12; k++) begin
      if (k % 2 == 0) sd2[1] = 24'h0B0000 + 24'(k);
      @(negedge clk);
      chk($sformatf("nohdr c%0d s_ready", k), 32'(srdy2), (k % 2 == 0) ? 32'b0010 : 32'd0);
      chk($sformatf("nohdr c%0d m_valid", k), 32'(mv2), 32'(k % 2));
      if (k % 2 == 1) chk($sformatf("nohdr c%0d m_data", k), 32'(md2), 32'(24'h0B0000 + 24'(k - 1)));
      cyc();
    end
    sv2 = '0;

    // ---------------- randomized against transaction model ----------------
    do_reset();
    q.delete();
    m_ptr  = N - 1;
    m_gid  = 0;
    m_idle = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      rstn = ($urandom_range(0, 99) != 0);
      sv   = 4'($urandom_range(0, 15));
      for (int l = 0; l < N; l++) sd[l] = 24'($urandom);
      mr   = ($urandom_range(0, 3) != 0);

      win = -1;
      if (m_idle && rstn) begin
        for (int k = 1; k <= N; k++) begin
          jj = 2'((m_ptr + k) % N);
          if (win < 0 && sv[jj]) win = int'(jj);
        end
      end

      @(negedge clk);
      chk("rand s_ready", 32'(srdy), (win >= 0) ? (32'd1 << win) : 32'd0);
      chk("rand m_valid", 32'(mv), 32'(!m_idle));
      chk("rand busy", 32'(busy), 32'(!m_idle));
      chk("rand grant_id", 32'(gid), 32'(m_gid));
      if (!m_idle) chk("rand m_data", 32'(md), 32'(q[0]));

      if (!rstn) begin
        q.delete();
        m_idle = 1'b1;
        m_ptr  = N - 1;
        m_gid  = 0;
      end else if (win >= 0) begin
        q.push_back(hdr(win));
        q.push_back(sd[win]);
        m_idle = 1'b0;
        m_ptr  = win;
        m_gid  = win;
      end else if (!m_idle && mr) begin
        void'(q.pop_front());
        if (q.size() == 0) m_idle = 1'b1;
      end
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
